// File: rtl/disp_pkg.sv
// Shared types and defaults for the display arbiter.
// Width helper keeps dwell counters at least one bit wide.
package disp_pkg;

  localparam int DISP_DW    = 11;
  localparam int DISP_DWELL = 50_000_000;

  typedef enum logic {
    IDLE,
    HOLD
  } disp_arb_state_t;

  function automatic int cnt_w(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/disp_arb_if.sv
// Requester-side bundle of the display arbiter.
// Master drives requests and values; slave is the arbiter.
interface disp_arb_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 11
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] val;
  logic                disp_sel;
  logic [DW-1:0]       disp_data;
  logic [N_REQ-1:0]    grant;
  logic                busy;

  modport master (
    output req, val,
    input  disp_sel, disp_data, grant, busy
  );

  modport slave (
    input  req, val,
    output disp_sel, disp_data, grant, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin winner search starting after i_last.
// The requester at i_last is scanned last.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_last,
  output logic                     o_found,
  output logic [$clog2(N_REQ)-1:0] o_idx
);

  localparam int LW = $clog2(N_REQ);

  logic [LW-1:0] w_j;

  // Scan from the far end so the nearest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_j = LW'((int'(i_last) + i) % N_REQ);
      if (i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/disp_arb.sv
// Round-robin owner selection for the shared 7-segment driver.
// Owner holds the display for a minimum dwell; value changes reload it.
module disp_arb
  import disp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = DISP_DW,
  parameter int DWELL = DISP_DWELL
) (
  input  logic     i_clk,
  input  logic     i_rst,
  disp_arb_if.slave bus
);

  localparam int LW = $clog2(N_REQ);
  localparam int CW = cnt_w(DWELL);

  disp_arb_state_t r_state, w_state_nx;
  logic [LW-1:0]    r_last, w_last_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic             r_sel, w_sel_nx;
  logic [DW-1:0]    r_data, w_data_nx;
  logic [N_REQ-1:0] r_grant, w_grant_nx;

  logic          w_found;
  logic [LW-1:0] w_idx;
  logic          w_hold, w_exp, w_other, w_own_req;
  logic          w_hand, w_ref, w_drop;
  logic [DW-1:0] w_own_val, w_win_val;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req   (bus.req),
    .i_last  (r_last),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // r_last doubles as the owner register while in HOLD.
  assign w_hold    = (r_state == HOLD);
  assign w_exp     = (r_cnt == '0);
  assign w_other   = w_found && (w_idx != r_last);
  assign w_own_req = bus.req[r_last];
  assign w_own_val = bus.val[int'(r_last)*DW +: DW];
  assign w_win_val = bus.val[int'(w_idx)*DW +: DW];

  assign w_hand = (!w_hold && w_found)
               || (w_hold && w_exp && w_other);
  assign w_ref  = w_hold && !w_hand && w_own_req
               && (w_own_val != r_data);
  assign w_drop = w_hold && w_exp && !w_other
               && !w_own_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_last  <= LW'(N_REQ - 1);
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nx;
      r_last  <= w_last_nx;
      r_cnt   <= w_cnt_nx;
      r_sel   <= w_sel_nx;
      r_data  <= w_data_nx;
      r_grant <= w_grant_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_found) w_state_nx = HOLD;
      HOLD:    if (w_drop)  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    w_sel_nx   = 1'b0;
    w_data_nx  = r_data;
    w_grant_nx = r_grant;
    w_last_nx  = r_last;
    w_cnt_nx   = (w_hold && !w_exp) ? r_cnt - 1'b1 : r_cnt;
    unique case (1'b1)
      w_hand: begin
        w_sel_nx   = 1'b1;
        w_data_nx  = w_win_val;
        w_grant_nx = N_REQ'(1) << w_idx;
        w_last_nx  = w_idx;
        w_cnt_nx   = CW'(DWELL - 1);
      end
      w_ref: begin
        w_sel_nx  = 1'b1;
        w_data_nx = w_own_val;
      end
      w_drop:  w_grant_nx = '0;
      default: ;
    endcase
  end

  assign bus.disp_sel  = r_sel;
  assign bus.disp_data = r_data;
  assign bus.grant     = r_grant;
  assign bus.busy      = w_hold;

endmodule
